// File: rtl/mips_dmem_bridge.sv
// Bridges the MIPS single-cycle data port onto a valid/ready memory bus,
// freezing the pipeline through cpu_en until each access completes.
module mips_dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        cpu_en,
  input  logic        cpu_mem_read_en,
  input  logic [3:0]  cpu_mem_write_en,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_write_data,
  output logic [31:0] cpu_mem_read_data,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [3:0]  bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  output logic [31:0] stall_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [31:0] resp_buf;
  logic        req;
  logic        req_is_read;

  assign req           = cpu_mem_read_en | (|cpu_mem_write_en);
  assign bus_req_valid = (state == REQ);
  // Any nonzero lane enable makes the access a write, so a zero mask marks a read.
  assign req_is_read   = (bus_req_we == 4'b0000);

  // The IDLE term is combinational from the CPU port; the CPU only uses en on
  // flops, so there is no loop through it.
  always_comb begin
    // NOTE: default first so every path assigns cpu_en and no latch is inferred.
    cpu_en = 1'b0;
    case (state)
      IDLE:    cpu_en = en & ~req;
      DONE:    cpu_en = en;
      default: cpu_en = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus_req_we        <= 4'b0000;
      bus_req_addr      <= 32'h0;
      bus_req_wdata     <= 32'h0;
      resp_buf          <= 32'h0;
      cpu_mem_read_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (en && req) begin
            bus_req_addr  <= {cpu_mem_addr[31:2], 2'b00};
            bus_req_we    <= cpu_mem_write_en;
            bus_req_wdata <= cpu_mem_write_data;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) state <= req_is_read ? WAIT : DONE;
        end
        WAIT: begin
          if (bus_resp_valid) begin
            resp_buf <= bus_resp_rdata;
            state    <= DONE;
          end
        end
        DONE: begin
          // Load data only moves when the read retires, so it stays valid for
          // the whole M-stage residency even across the next access's stall.
          if (en) begin
            state <= IDLE;
            if (req_is_read) cpu_mem_read_data <= resp_buf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 32'h0;
    end else if (en && !cpu_en && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Directed bench for mips_dmem_bridge: bus handshakes are driven by a small
// scripted responder and all expected values are hand-computed constants.
module tb_mips_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cpu_en;
  logic        cpu_mem_read_en;
  logic [3:0]  cpu_mem_write_en;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_write_data;
  logic [31:0] cpu_mem_read_data;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [3:0]  bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;
  logic [31:0] stall_count;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int low;
  int hs0;

  mips_dmem_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .cpu_en             (cpu_en),
    .cpu_mem_read_en    (cpu_mem_read_en),
    .cpu_mem_write_en   (cpu_mem_write_en),
    .cpu_mem_addr       (cpu_mem_addr),
    .cpu_mem_write_data (cpu_mem_write_data),
    .cpu_mem_read_data  (cpu_mem_read_data),
    .bus_req_valid      (bus_req_valid),
    .bus_req_ready      (bus_req_ready),
    .bus_req_we         (bus_req_we),
    .bus_req_addr       (bus_req_addr),
    .bus_req_wdata      (bus_req_wdata),
    .bus_resp_valid     (bus_resp_valid),
    .bus_resp_rdata     (bus_resp_rdata),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_req_valid && bus_req_ready) hs_count++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    cpu_mem_read_en = 1'b0;
    cpu_mem_write_en = 4'b0000;
    cpu_mem_addr = 32'h0;
    cpu_mem_write_data = 32'h0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Presents one access and plays the bus side until DONE. ready_wait counts
  // REQ cycles with ready low; resp_wait counts cycles from acceptance to the
  // response. A bogus response is pulsed in the acceptance cycle.
  task automatic access(input logic rd_i, input logic [3:0] we_i,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_addr, input int ready_wait,
                        input int resp_wait, input logic [31:0] rsp,
                        input logic [31:0] hold_rd, output int low_o);
    int  req_seen;
    int  since_acc;
    bit  accepted;
    bit  done;
    low_o = 0; req_seen = 0; since_acc = 0; accepted = 0; done = 0;
    cpu_mem_read_en = rd_i;
    cpu_mem_write_en = we_i;
    cpu_mem_addr = a;
    cpu_mem_write_data = wd;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      bus_req_ready = 1'b0;
      bus_resp_valid = 1'b0;
      bus_resp_rdata = 32'h0;
      if (accepted) begin
        since_acc++;
        if (since_acc == resp_wait) begin
          bus_resp_valid = 1'b1;
          bus_resp_rdata = rsp;
        end
      end
      #1;
      chk("hold_rd", cpu_mem_read_data, hold_rd);
      if (bus_req_valid) begin
        chk("req_addr", bus_req_addr, exp_addr);
        chk("req_we", 32'(bus_req_we), 32'(we_i));
        chk("req_wdata", bus_req_wdata, wd);
        if (req_seen == ready_wait) begin
          bus_req_ready = 1'b1;
          bus_resp_valid = 1'b1;
          bus_resp_rdata = 32'hBAAD_F00D;
          accepted = 1;
        end
        req_seen++;
      end
      #1;
      if (cpu_en) begin
        done = 1;
        cpu_mem_read_en = 1'b0;
        cpu_mem_write_en = 4'b0000;
      end else begin
        low_o++;
      end
      step();
    end
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    chk("access_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while rst is held.
    rst = 1'b1;
    en = 1'b1;
    cpu_mem_read_en = 1'b0;
    cpu_mem_write_en = 4'b0000;
    cpu_mem_addr = 32'h0;
    cpu_mem_write_data = 32'h0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    #1;
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_we", 32'(bus_req_we), 32'd0);
    chk("rst_addr", bus_req_addr, 32'h0);
    chk("rst_wdata", bus_req_wdata, 32'h0);
    chk("rst_rdata", cpu_mem_read_data, 32'h0);
    chk("rst_stall", stall_count, 32'h0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd1);
    do_reset();

    // Non-memory instruction: cpu_en follows en directly.
    chk("nonmem_en1", 32'(cpu_en), 32'd1);
    en = 1'b0; #1;
    chk("nonmem_en0", 32'(cpu_en), 32'd0);
    en = 1'b1; #1;

    // Load from 0x1006: ready at once, response two cycles after acceptance.
    access(1'b1, 4'b0000, 32'h1006, 32'h0, 32'h1004, 0, 2, 32'hDEAD_BEEF, 32'h0, low);
    chk("load_low", 32'(low), 32'd4);
    chk("load_rdata", cpu_mem_read_data, 32'hDEAD_BEEF);
    chk("load_stall", stall_count, 32'd4);

    // Byte store with ready low for three REQ cycles.
    do_reset();
    hs0 = hs_count;
    access(1'b0, 4'b0010, 32'h2002, 32'h5555_5555, 32'h2000, 3, 0, 32'h0, 32'h0, low);
    chk("store_low", 32'(low), 32'd5);
    chk("store_hs", 32'(hs_count - hs0), 32'd1);
    chk("store_stall", stall_count, 32'd5);
    chk("store_rdata", cpu_mem_read_data, 32'h0);

    // Store with read_en also set is still a write.
    access(1'b1, 4'b1111, 32'h2010, 32'hA5A5_A5A5, 32'h2010, 0, 0, 32'h0, 32'h0, low);
    chk("rw_low", 32'(low), 32'd2);

    // Back-to-back loads; the first value must survive the second stall.
    do_reset();
    access(1'b1, 4'b0000, 32'h3000, 32'h0, 32'h3000, 0, 1, 32'h1111_1111, 32'h0, low);
    chk("b2b_low1", 32'(low), 32'd3);
    chk("b2b_rdata1", cpu_mem_read_data, 32'h1111_1111);
    access(1'b1, 4'b0000, 32'h3007, 32'h0, 32'h3004, 0, 5, 32'h2222_2222, 32'h1111_1111, low);
    chk("b2b_low2", 32'(low), 32'd7);
    chk("b2b_rdata2", cpu_mem_read_data, 32'h2222_2222);
    chk("b2b_stall", stall_count, 32'd10);

    // en dropped during WAIT: completes the bus access, then holds in DONE.
    do_reset();
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h4000;
    #1; chk("en_idle", 32'(cpu_en), 32'd0);
    step();
    bus_req_ready = 1'b1;
    #1; chk("en_req_valid", 32'(bus_req_valid), 32'd1);
    step();
    bus_req_ready = 1'b0;
    en = 1'b0;
    #1; chk("en_wait_cpu", 32'(cpu_en), 32'd0);
    chk("en_wait_stall", stall_count, 32'd2);
    step();
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'hCAFE_F00D;
    step();
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("done_hold_en", 32'(cpu_en), 32'd0);
      chk("done_hold_stall", stall_count, 32'd2);
      chk("done_hold_rdata", cpu_mem_read_data, 32'h0);
      step();
    end
    en = 1'b1;
    #1; chk("done_retire_en", 32'(cpu_en), 32'd1);
    cpu_mem_read_en = 1'b0;
    step();
    chk("done_retire_rdata", cpu_mem_read_data, 32'hCAFE_F00D);
    chk("done_retire_stall", stall_count, 32'd2);

    // Spurious response in IDLE is ignored.
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h0BAD_BAD0;
    #1;
    chk("spur_cpu_en", 32'(cpu_en), 32'd1);
    chk("spur_valid", 32'(bus_req_valid), 32'd0);
    step();
    bus_resp_valid = 1'b0;
    #1;
    chk("spur_rdata", cpu_mem_read_data, 32'hCAFE_F00D);
    chk("spur_valid2", 32'(bus_req_valid), 32'd0);

    // Reset while in WAIT abandons the access immediately.
    do_reset();
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h5000;
    step();
    bus_req_ready = 1'b1;
    #1;
    step();
    bus_req_ready = 1'b0;
    #1;
    chk("wait_pre_stall", stall_count, 32'd2);
    chk("wait_pre_cpu_en", 32'(cpu_en), 32'd0);
    cpu_mem_read_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("wrst_valid", 32'(bus_req_valid), 32'd0);
    chk("wrst_stall", stall_count, 32'd0);
    chk("wrst_cpu_en", 32'(cpu_en), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("wrst_rdata", cpu_mem_read_data, 32'h0);

    // Saturation: preload near the top, then three stall cycles.
    do_reset();
    force dut.stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count;
    #1;
    chk("sat_preload", stall_count, 32'hFFFF_FFFE);
    access(1'b1, 4'b0000, 32'h6000, 32'h0, 32'h6000, 0, 1, 32'h7777_7777, 32'h0, low);
    chk("sat_low", 32'(low), 32'd3);
    chk("sat_value", stall_count, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_dmem_bridge.md
# mips_dmem_bridge

Data-memory bridge between the MIPS CPU's single-cycle data port and a variable-latency valid/ready memory bus. It accepts the X-stage load/store presented by the CPU, issues it on the bus, and holds the pipeline frozen through the CPU enable until the access completes. It registers returned load data so the CPU's M stage sees a stable value. It also counts the stall cycles it causes.

## Interface
- No parameters; all widths fixed at 32-bit data/address, 4 byte lanes.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global run enable from the SoC.
- cpu_en  out  1  enable driven to the CPU's `en`; low freezes the pipeline.
- cpu_mem_read_en  in  1  CPU load request (X stage).
- cpu_mem_write_en  in  4  CPU store byte-lane enables (X stage).
- cpu_mem_addr  in  32  CPU byte address.
- cpu_mem_write_data  in  32  CPU store data, already lane-replicated.
- cpu_mem_read_data  out  32  registered load data for the CPU M stage.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_req_we  out  4  byte write enables; 0000 means read.
- bus_req_addr  out  32  word-aligned address, {cpu_mem_addr[31:2],2'b00}.
- bus_req_wdata  out  32  write data.
- bus_resp_valid  in  1  read response valid; single-cycle pulse.
- bus_resp_rdata  in  32  read response data.
- stall_count  out  32  saturating count of bridge-induced stall cycles.

## Operation
- req = cpu_mem_read_en | (|cpu_mem_write_en). When cpu_mem_write_en is nonzero, the request is a write regardless of cpu_mem_read_en.
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - cpu_en = en & ~req. This is a combinational path from the CPU port; it is loop-free because the CPU uses `en` only on flops.
  - If en & req: latch addr, we (write_en, or 0000 for a read), and wdata into request registers, then go to REQ.
- REQ:
  - bus_req_valid = 1, with the payload taken from the request registers and held stable until ready.
  - On bus_req_ready: a write goes to DONE; a read goes to WAIT.
- WAIT:
  - On bus_resp_valid: capture bus_resp_rdata into resp_buf and go to DONE.
- DONE:
  - cpu_en = en.
  - If en: go to IDLE, and load cpu_mem_read_data <= resp_buf if the retired access was a read.
  - If en = 0: stay in DONE.
- cpu_mem_read_data changes only on the edge where a read retires (DONE & en). It therefore stays valid for the load's entire M-stage residency, including later stalls caused by the next request.
- bus_resp_valid outside WAIT, including in the acceptance cycle in REQ, is ignored.
- While en = 0 in REQ or WAIT, the bus transaction still completes; only the exit from DONE waits for en.
- cpu_en = 0 in REQ and WAIT.
- stall_count increments on every cycle where en & ~cpu_en, and saturates at 0xFFFFFFFF with no wrap.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - bus_req_valid = 0, bus_req_we = 0, bus_req_addr = 0, bus_req_wdata = 0.
  - cpu_mem_read_data = 0, resp_buf = 0, stall_count = 0.
  - cpu_en follows the IDLE equation.
- Reset mid-transaction abandons the access. The bus shares rst, so no orphaned response arrives.
- Read, ready and response at the earliest possible cycles:
  - c0 IDLE (stall), c1 REQ with ready, c2 WAIT with resp, c3 DONE with cpu_en = 1.
  - cpu_mem_read_data is valid from c4.
  - 3 stall cycles.
- Write, ready in the first REQ cycle: c0 IDLE (stall), c1 REQ, c2 DONE. 2 stall cycles.
- Each cycle of bus_req_ready low adds one stall cycle; each extra WAIT cycle adds one.
- A non-memory instruction gives cpu_en = en with zero added latency.
- Back-to-back accesses: the next request is seen in the IDLE cycle right after DONE. There is never a duplicate issue, because DONE always exits to IDLE on the advancing edge.

## Test plan
- Reset while in WAIT:
  - Stimulus: assert rst.
  - Required: state IDLE, bus_req_valid = 0, and stall_count = 0 in the same cycle.
  - Required: cpu_mem_read_data = 0 after release.
- Load from 0x1006:
  - Stimulus: ready in the first REQ cycle; resp 0xDEADBEEF two cycles after acceptance.
  - Required: bus_req_addr = 0x1004 and bus_req_we = 0000.
  - Required: cpu_en low for 4 cycles, and cpu_mem_read_data = 0xDEADBEEF from the cycle after DONE.
  - Required: stall_count = 4.
- Store byte:
  - Stimulus: write_en = 0010, addr 0x2002, data 0x55555555; ready held low for 3 REQ cycles.
  - Required: payload stable throughout, and exactly one accepted handshake.
  - Required: cpu_en low for 5 cycles.
- Load 0x11111111 followed immediately by load 0x22222222 (resp delayed 5 cycles):
  - Required: cpu_mem_read_data remains 0x11111111 through the second load's stall.
  - Required: it becomes 0x22222222 only after the second DONE.
- Enable and spurious-response handling:
  - Stimulus: drop en during WAIT, response arrives, en low for 3 more cycles.
  - Required: the FSM holds in DONE with cpu_en = 0 and stall_count unchanged; it retires when en rises.
  - Stimulus: bus_resp_valid pulsed in IDLE.
  - Required: it is ignored.
- stall_count preloaded via force to 0xFFFFFFFE, then 3 stall cycles: required value 0xFFFFFFFF, no wrap.
